exe_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, directly downstream of decode. Each cycle it evaluates the ALU on decode's registered operands and registers the result with the memory and writeback controls for the memory stage. It also runs an independent multi-cycle multiply/divide unit. That unit drives a HI/LO write port and a busy signal that the hazard unit uses to stall decode.

---
 rtl/exe_if.sv | 35 +++
 rtl/exe_stage.sv | 104 ++++++++++
 tb/tb_exe_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/exe_if.sv
// exe_if: decode-to-execute operands and controls, execute-to-memory controls and HI/LO write port.
interface exe_if;
  logic [3:0]  de_aluop;
  logic [31:0] de_alusrc1, de_alusrc2;
  logic        de_mult_en, de_div_en, de_is_signed;
  logic [31:0] de_MD_src1, de_MD_src2;
  logic        de_mem_en;
  logic [3:0]  de_mem_wen;
  logic [31:0] de_mem_wdata;
  logic        de_reg_en, de_mem_read;
  logic [5:0]  de_reg_waddr;
  logic [31:0] ex_alu_result;
  logic        ex_mem_en;
  logic [3:0]  ex_mem_wen;
  logic [31:0] ex_mem_wdata;
  logic        ex_reg_en, ex_mem_read;
  logic [5:0]  ex_reg_waddr;
  logic        ex_md_we;
  logic [31:0] ex_md_hi, ex_md_lo;
  logic        ex_busy;
  modport master (
    output de_aluop, de_alusrc1, de_alusrc2, de_mult_en, de_div_en, de_is_signed,
           de_MD_src1, de_MD_src2, de_mem_en, de_mem_wen, de_mem_wdata, de_reg_en,
           de_mem_read, de_reg_waddr,
    input  ex_alu_result, ex_mem_en, ex_mem_wen, ex_mem_wdata, ex_reg_en, ex_mem_read,
           ex_reg_waddr, ex_md_we, ex_md_hi, ex_md_lo, ex_busy
  );
  modport slave (
    input  de_aluop, de_alusrc1, de_alusrc2, de_mult_en, de_div_en, de_is_signed,
           de_MD_src1, de_MD_src2, de_mem_en, de_mem_wen, de_mem_wdata, de_reg_en,
           de_mem_read, de_reg_waddr,
    output ex_alu_result, ex_mem_en, ex_mem_wen, ex_mem_wdata, ex_reg_en, ex_mem_read,
           ex_reg_waddr, ex_md_we, ex_md_hi, ex_md_lo, ex_busy
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage with registered ALU/control path and a multi-cycle mult/div unit.
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input logic  clk,
  input logic  resetn,
  exe_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam int CW = $clog2(DIV_CYCLES + 1);
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   alu_d, alu_q, wdata_q, a_q, b_q, rem_q, quo_q, hi_q, lo_q;
  logic [3:0]    wen_q;
  logic [5:0]    waddr_q;
  logic          mem_en_q, reg_en_q, mem_read_q, sg_q;
  logic [4:0]    sh;
  logic [63:0]   prod;
  logic [32:0]   trial;
  logic          ge;
  logic [31:0]   dvs, rem_n, quo_n, q_fix, r_fix;
  assign sh = bus.de_alusrc1[4:0];
  always_comb begin
    alu_d = '0;
    case (bus.de_aluop)
      4'h0: alu_d = bus.de_alusrc1 & bus.de_alusrc2;
      4'h1: alu_d = bus.de_alusrc1 | bus.de_alusrc2;
      4'h2: alu_d = bus.de_alusrc1 + bus.de_alusrc2;
      4'h3: alu_d = bus.de_alusrc1 - bus.de_alusrc2;
      4'h4: alu_d = {31'b0, $signed(bus.de_alusrc1) < $signed(bus.de_alusrc2)};
      4'h5: alu_d = {31'b0, bus.de_alusrc1 < bus.de_alusrc2};
      4'h6, 4'h8: alu_d = bus.de_alusrc2 << sh;
      4'h7: alu_d = bus.de_alusrc2 >> sh;
      4'h9: alu_d = $signed(bus.de_alusrc2) >>> sh;
      4'hA: alu_d = {bus.de_alusrc2[15:0], 16'h0};
      4'hB: alu_d = bus.de_alusrc1 ^ bus.de_alusrc2;
      4'hC: alu_d = ~(bus.de_alusrc1 | bus.de_alusrc2);
      default: alu_d = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_q <= '0; mem_en_q <= 1'b0; wen_q <= '0; wdata_q <= '0;
      reg_en_q <= 1'b0; mem_read_q <= 1'b0; waddr_q <= '0;
    end else begin
      alu_q <= alu_d; mem_en_q <= bus.de_mem_en; wen_q <= bus.de_mem_wen;
      wdata_q <= bus.de_mem_wdata; reg_en_q <= bus.de_reg_en;
      mem_read_q <= bus.de_mem_read; waddr_q <= bus.de_reg_waddr;
    end
  end
  // Low 64 bits of the product of 64-bit extended operands are exact for both signednesses.
  assign prod  = {{32{sg_q & a_q[31]}}, a_q} * {{32{sg_q & b_q[31]}}, b_q};
  assign dvs   = (sg_q & b_q[31]) ? -b_q : b_q;
  assign trial = {rem_q, quo_q[31]};
  assign ge    = trial >= {1'b0, dvs};
  assign rem_n = ge ? 32'(trial - {1'b0, dvs}) : trial[31:0];
  assign quo_n = {quo_q[30:0], ge};
  assign q_fix = (b_q == '0) ? '1 : ((sg_q & (a_q[31] ^ b_q[31])) ? -quo_n : quo_n);
  assign r_fix = (b_q == '0) ? a_q : ((sg_q & a_q[31]) ? -rem_n : rem_n);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE; cnt_q <= '0; a_q <= '0; b_q <= '0; sg_q <= 1'b0;
      rem_q <= '0; quo_q <= '0; hi_q <= '0; lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.de_div_en || bus.de_mult_en) begin
          a_q     <= bus.de_MD_src1;
          b_q     <= bus.de_MD_src2;
          sg_q    <= bus.de_is_signed;
          rem_q   <= '0;
          quo_q   <= (bus.de_is_signed & bus.de_MD_src1[31]) ? -bus.de_MD_src1 : bus.de_MD_src1;
          cnt_q   <= '0;
          state_q <= bus.de_div_en ? DIV : MUL;
        end
        MUL: begin
          {hi_q, lo_q} <= prod;
          state_q      <= DONE;
        end
        DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DIV_CYCLES - 1)) begin
            hi_q    <= r_fix;
            lo_q    <= q_fix;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ex_alu_result = alu_q;
  assign bus.ex_mem_en     = mem_en_q;
  assign bus.ex_mem_wen    = wen_q;
  assign bus.ex_mem_wdata  = wdata_q;
  assign bus.ex_reg_en     = reg_en_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_reg_waddr  = waddr_q;
  assign bus.ex_md_we      = state_q == DONE;
  assign bus.ex_md_hi      = hi_q;
  assign bus.ex_md_lo      = lo_q;
  assign bus.ex_busy       = state_q != IDLE;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed and random checks of the execute stage against an arithmetic reference model.
module tb_exe_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exe_if bus();
  exe_stage #(.DIV_CYCLES(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint d  = longint'(1) << a[4:0];
    longint ub = longint'(b);
    longint sb = longint'($signed(b));
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return 32'(longint'(a) + ub);
      4'h3: return 32'(longint'(a) - ub);
      4'h4: return (longint'($signed(a)) < sb) ? 32'd1 : 32'd0;
      4'h5: return (longint'(a) < ub) ? 32'd1 : 32'd0;
      4'h6, 4'h8: return 32'(ub * d);
      4'h7: return 32'(ub / d);
      4'h9: return 32'((sb - (((sb % d) + d) % d)) / d);
      4'hA: return 32'(longint'(b[15:0]) * 65536);
      4'hB: return a ^ b;
      4'hC: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [63:0] md_ref(input bit dv, input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa = sg ? longint'($signed(a)) : longint'(a);
    longint sv = sg ? longint'($signed(b)) : longint'(b);
    if (!dv) return 64'(sa * sv);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {32'(sa % sv), 32'(sa / sv)};
  endfunction
  function automatic logic [44:0] ctrl_out();
    return {bus.ex_mem_en, bus.ex_mem_wen, bus.ex_mem_wdata, bus.ex_reg_en, bus.ex_mem_read, bus.ex_reg_waddr};
  endfunction
  task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.de_aluop = op; bus.de_alusrc1 = a; bus.de_alusrc2 = b;
  endtask
  task automatic md_op(input string tag, input bit dv, input bit sg, input logic [31:0] a,
                       input logic [31:0] b, input bit inject);
    int busy_n = 0, we_n = 0, we_at = 0;
    logic [63:0] got = '0;
    logic [63:0] exp = md_ref(dv, sg, a, b);
    bus.de_div_en = dv; bus.de_mult_en = !dv; bus.de_is_signed = sg;
    bus.de_MD_src1 = a; bus.de_MD_src2 = b;
    step();
    bus.de_div_en = 1'b0; bus.de_mult_en = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (bus.ex_busy) busy_n++;
      if (bus.ex_md_we) begin
        we_n++; we_at = i; got = {bus.ex_md_hi, bus.ex_md_lo};
      end
      if (!bus.ex_busy) break;
      bus.de_mult_en = inject && i == 5;
      bus.de_MD_src1 = $urandom; bus.de_MD_src2 = $urandom;
      step();
    end
    bus.de_mult_en = 1'b0;
    chk({tag, " result"}, got, exp);
    chk({tag, " busy cycles"}, 64'(busy_n), dv ? 64'd33 : 64'd2);
    chk({tag, " we count"}, 64'(we_n), 64'd1);
    chk({tag, " we cycle"}, 64'(we_at), dv ? 64'd33 : 64'd2);
    chk({tag, " hold"}, {bus.ex_md_hi, bus.ex_md_lo}, exp);
  endtask
  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, prev;
    logic [44:0] ctl;
    int          we_n;
    bus.de_aluop = '0; bus.de_alusrc1 = '0; bus.de_alusrc2 = '0;
    bus.de_mult_en = 1'b0; bus.de_div_en = 1'b0; bus.de_is_signed = 1'b0;
    bus.de_MD_src1 = '0; bus.de_MD_src2 = '0; bus.de_mem_en = 1'b0; bus.de_mem_wen = '0;
    bus.de_mem_wdata = '0; bus.de_reg_en = 1'b0; bus.de_mem_read = 1'b0; bus.de_reg_waddr = '0;
    step(); step();
    chk("reset alu", 64'(bus.ex_alu_result), 64'd0);
    chk("reset ctrl", 64'(ctrl_out()), 64'd0);
    chk("reset md", {bus.ex_md_hi, bus.ex_md_lo}, 64'd0);
    chk("reset flags", {62'd0, bus.ex_busy, bus.ex_md_we}, 64'd0);
    resetn = 1'b1;
    drive_alu(4'h2, 32'h7FFF_FFFF, 32'h1); step();
    chk("add wrap", 64'(bus.ex_alu_result), 64'h8000_0000);
    drive_alu(4'h4, 32'hFFFF_FFFF, 32'h1); step();
    chk("slt", 64'(bus.ex_alu_result), 64'd1);
    drive_alu(4'h5, 32'hFFFF_FFFF, 32'h1); step();
    chk("sltu", 64'(bus.ex_alu_result), 64'd0);
    drive_alu(4'h9, 32'd4, 32'h8000_0000); step();
    chk("sra", 64'(bus.ex_alu_result), 64'hF800_0000);
    drive_alu(4'hA, 32'd0, 32'h1234);
    #2 chk("latency hold", 64'(bus.ex_alu_result), 64'hF800_0000);
    step();
    chk("lui", 64'(bus.ex_alu_result), 64'h1234_0000);
    drive_alu(4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
    chk("undef op", 64'(bus.ex_alu_result), 64'd0);
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
      drive_alu(op, a, b);
      ctl = {1'($urandom), 4'($urandom), 32'($urandom), 1'($urandom), 1'($urandom), 6'($urandom)};
      {bus.de_mem_en, bus.de_mem_wen, bus.de_mem_wdata, bus.de_reg_en, bus.de_mem_read, bus.de_reg_waddr} = ctl;
      step();
      chk($sformatf("alu op%0h", op), 64'(bus.ex_alu_result), 64'(alu_ref(op, a, b)));
      chk("ctrl pipe", 64'(ctrl_out()), 64'(ctl));
    end
    prev = bus.ex_alu_result;
    md_op("sdiv 7/-2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    chk("sdiv const", {bus.ex_md_hi, bus.ex_md_lo}, 64'h0000_0001_FFFF_FFFD);
    md_op("smul -3*5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("smul const", {bus.ex_md_hi, bus.ex_md_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    md_op("umul", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("umul const", {bus.ex_md_hi, bus.ex_md_lo}, 64'h0000_0001_FFFF_FFFE);
    md_op("udiv by 0", 1'b1, 1'b0, 32'd100, 32'd0, 1'b0);
    chk("udiv0 const", {bus.ex_md_hi, bus.ex_md_lo}, 64'h0000_0064_FFFF_FFFF);
    md_op("sdiv by 0", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd0, 1'b0);
    md_op("sdiv min/-1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    md_op("div with mult inject", 1'b1, 1'b0, 32'd1000, 32'd7, 1'b1);
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      md_op($sformatf("rand md%0d", i), 1'($urandom), 1'($urandom), a, b, 1'b0);
    end
    bus.de_div_en = 1'b1; bus.de_is_signed = 1'b1;
    bus.de_MD_src1 = 32'd12345; bus.de_MD_src2 = 32'd17;
    step();
    bus.de_div_en = 1'b0;
    for (int i = 0; i < 9; i++) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("abort busy", 64'(bus.ex_busy), 64'd0);
    chk("abort we", 64'(bus.ex_md_we), 64'd0);
    chk("abort md", {bus.ex_md_hi, bus.ex_md_lo}, 64'd0);
    chk("abort alu", 64'(bus.ex_alu_result), 64'd0);
    chk("abort ctrl", 64'(ctrl_out()), 64'd0);
    we_n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ex_md_we || bus.ex_busy) we_n++;
    end
    chk("no write after abort", 64'(we_n), 64'd0);
    md_op("div after reset", 1'b1, 1'b1, 32'hFFFF_CFC7, 32'd17, 1'b0);
    chk("alu before md", 64'(prev), 64'(prev));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
